gearbox_block_lock_ctrl: RTL and testbench
==========================================

// Module: gearbox_block_lock_ctrl
// PURPOSE
//  Block-lock controller for the 40->66 receive gearbox. Inspects the 2-bit
//  sync header of each recovered 66-bit word, commands one-bit slips until
//  headers are consistently valid, then declares lock. Once locked, it
//  monitors the header error rate and drops lock when errors exceed a
//  threshold. Sits between the 40->66 gearbox (slip input, header/valid
//  outputs) and the downstream 64b/66b decoder.
// PARAMETERS
//  LOCK_CNT    64  consecutive valid headers required to declare lock (>=2)
//  BAD_WINDOW  64  window length, in valid words, for error counting when locked
//  BAD_MAX     16  bad headers within one window that force loss of lock (>=1)
//  SLIP_WAIT   4   valid words ignored after each slip while gearbox realigns
// PORTS
//  clk            in   1   clock
//  sclr           in   1   synchronous active-high reset
//  slip_enable    in   1   1: bad header in HUNT triggers a slip; 0: never slip
//  din_valid      in   1   header below belongs to a new 66-bit word
//  din_hdr        in   2   sync header of that word (bits 1:0, lsbit first)
//  slip           out  1   one-cycle pulse: gearbox shifts alignment one bit
//  slipping       out  1   high while in SLIP or WAIT state
//  word_locked    out  1   block lock achieved
//  slip_count     out  16  saturating count of slip pulses issued
//  lock_loss_count out 8   saturating count of LOCKED->SLIP transitions
// BEHAVIOUR
//  - Header good iff din_hdr==2'b01 or 2'b10; 00/11 are bad. Only din_valid
//    cycles are evaluated; all counters hold when din_valid=0.
//  - Reset (sclr=1, sampled at posedge): state=HUNT, all counters 0,
//    slip=0, slipping=0, word_locked=0, slip_count=0, lock_loss_count=0.
//    sclr overrides any in-progress slip/wait; no slip pulse emitted.
//  - HUNT: good -> good_cnt+1; when the LOCK_CNT-th consecutive good header
//    is sampled, go LOCKED; word_locked=1 on the following cycle. Bad with
//    slip_enable=1 -> SLIP, good_cnt=0. Bad with slip_enable=0 -> good_cnt=0,
//    stay HUNT.
//  - SLIP: lasts exactly one cycle; slip=1, slip_count+1 (saturate at FFFF).
//    din_valid in this cycle is ignored. Next state WAIT, wait_cnt=0.
//  - WAIT: each valid word increments wait_cnt, headers ignored; after the
//    SLIP_WAIT-th valid word go HUNT with good_cnt=0.
//  - LOCKED: win_cnt counts valid words 0..BAD_WINDOW-1; bad_cnt counts bad
//    headers. A bad header that makes bad_cnt reach BAD_MAX -> SLIP (even if
//    slip_enable=0 the state drops lock; slip pulse only if slip_enable=1,
//    else go HUNT directly), word_locked=0 next cycle, lock_loss_count+1
//    (saturate at FF). Otherwise, on the valid word with win_cnt=BAD_WINDOW-1,
//    the threshold check is applied first, then win_cnt and bad_cnt clear to 0.
//  - slipping = (state==SLIP)||(state==WAIT); all outputs registered.
//  - Counter widths: $clog2(param+1); no wrap except win_cnt window restart.
// TESTING
//  1 Stream 64 valid words hdr=01 after sclr -> word_locked=1 one cycle after
//    64th word; slip never asserted; slip_count=0.
//  2 Headers 11 for 3 words, then 01 forever, slip_enable=1, SLIP_WAIT=4 ->
//    slip pulses 1 cycle each word-spaced per WAIT, slip_count=3, lock after
//    64 further good words.
//  3 Locked; inject 15 bad headers in a 64-word window -> stays locked; 16th
//    bad in same window -> word_locked=0, lock_loss_count=1, slip pulse.
//  4 Locked; 15 bad at end of window 1, 15 bad in window 2 -> lock held
//    (counters cleared at window boundary).
//  5 slip_enable=0, all headers 00 for 200 words -> slip never asserted,
//    word_locked=0, slip_count=0.
//  6 Assert sclr during WAIT and during LOCKED -> next cycle all outputs 0,
//    state HUNT; relock needs full 64 good words. Loopback: 66->40 gearbox
//    feeding 40->66 gearbox + this block locks at all 40 bit offsets.

Source files
------------

// File: rtl/gearbox_block_lock_ctrl.sv
// Block-lock controller for a 40->66 receive gearbox: slips until sync headers are
// consistently valid, declares lock, and drops lock when the header error rate gets too high.
module gearbox_block_lock_ctrl #(
    parameter int unsigned LOCK_CNT   = 64,
    parameter int unsigned BAD_WINDOW = 64,
    parameter int unsigned BAD_MAX    = 16,
    parameter int unsigned SLIP_WAIT  = 4
) (
    input  logic        clk,
    input  logic        sclr,
    input  logic        slip_enable,
    input  logic        din_valid,
    input  logic [1:0]  din_hdr,
    output logic        slip,
    output logic        slipping,
    output logic        word_locked,
    output logic [15:0] slip_count,
    output logic [7:0]  lock_loss_count
);

    localparam int unsigned GW = $clog2(LOCK_CNT + 1);
    localparam int unsigned WW = $clog2(BAD_WINDOW + 1);
    localparam int unsigned BW = $clog2(BAD_MAX + 1);
    localparam int unsigned SW = $clog2(SLIP_WAIT + 1);

    typedef enum logic [1:0] {StHunt, StSlip, StWait, StLocked} state_t;

    state_t        state;
    logic [GW-1:0] good_cnt;
    logic [WW-1:0] win_cnt;
    logic [BW-1:0] bad_cnt;
    logic [SW-1:0] wait_cnt;
    logic          hdr_good;

    // 01 and 10 are the only legal sync headers
    assign hdr_good = din_hdr[1] ^ din_hdr[0];

    always_ff @(posedge clk) begin
        if (sclr) begin
            state           <= StHunt;
            good_cnt        <= '0;
            win_cnt         <= '0;
            bad_cnt         <= '0;
            wait_cnt        <= '0;
            slip            <= 1'b0;
            slipping        <= 1'b0;
            word_locked     <= 1'b0;
            slip_count      <= '0;
            lock_loss_count <= '0;
        end else begin
            unique case (state)
                StHunt: begin
                    if (din_valid) begin
                        if (hdr_good) begin
                            if (good_cnt == GW'(LOCK_CNT - 1)) begin
                                state       <= StLocked;
                                good_cnt    <= '0;
                                win_cnt     <= '0;
                                bad_cnt     <= '0;
                                word_locked <= 1'b1;
                            end else begin
                                good_cnt <= good_cnt + 1'b1;
                            end
                        end else begin
                            good_cnt <= '0;
                            if (slip_enable) begin
                                state    <= StSlip;
                                slip     <= 1'b1;
                                slipping <= 1'b1;
                                if (slip_count != 16'hFFFF) slip_count <= slip_count + 16'd1;
                            end
                        end
                    end
                end
                StSlip: begin
                    // Word arriving during the slip cycle is discarded
                    state    <= StWait;
                    slip     <= 1'b0;
                    wait_cnt <= '0;
                end
                StWait: begin
                    if (din_valid) begin
                        if (wait_cnt == SW'(SLIP_WAIT - 1)) begin
                            state    <= StHunt;
                            good_cnt <= '0;
                            wait_cnt <= '0;
                            slipping <= 1'b0;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                end
                StLocked: begin
                    if (din_valid) begin
                        if (!hdr_good && bad_cnt == BW'(BAD_MAX - 1)) begin
                            word_locked <= 1'b0;
                            win_cnt     <= '0;
                            bad_cnt     <= '0;
                            good_cnt    <= '0;
                            if (lock_loss_count != 8'hFF) begin
                                lock_loss_count <= lock_loss_count + 8'd1;
                            end
                            if (slip_enable) begin
                                state    <= StSlip;
                                slip     <= 1'b1;
                                slipping <= 1'b1;
                                if (slip_count != 16'hFFFF) slip_count <= slip_count + 16'd1;
                            end else begin
                                state <= StHunt;
                            end
                        end else if (win_cnt == WW'(BAD_WINDOW - 1)) begin
                            win_cnt <= '0;
                            bad_cnt <= '0;
                        end else begin
                            win_cnt <= win_cnt + 1'b1;
                            bad_cnt <= bad_cnt + BW'(!hdr_good);
                        end
                    end
                end
                default: state <= StHunt;
            endcase
        end
    end

endmodule

// File: tb/tb_gearbox_block_lock_ctrl.sv
// Directed bench for gearbox_block_lock_ctrl with default parameters (64/64/16/4).
module tb_gearbox_block_lock_ctrl;

    logic        clk = 1'b0;
    logic        sclr = 1'b1;
    logic        slip_enable = 1'b1;
    logic        din_valid = 1'b0;
    logic [1:0]  din_hdr = 2'b00;
    logic        slip;
    logic        slipping;
    logic        word_locked;
    logic [15:0] slip_count;
    logic [7:0]  lock_loss_count;

    int vectors = 0;
    int miscompares = 0;
    int slip_seen = 0;
    int slip_base = 0;

    gearbox_block_lock_ctrl dut (
        .clk             (clk),
        .sclr            (sclr),
        .slip_enable     (slip_enable),
        .din_valid       (din_valid),
        .din_hdr         (din_hdr),
        .slip            (slip),
        .slipping        (slipping),
        .word_locked     (word_locked),
        .slip_count      (slip_count),
        .lock_loss_count (lock_loss_count)
    );

    always #5 clk = ~clk;

    // Each slip pulse is seen high at exactly one rising edge
    always @(posedge clk) if (slip === 1'b1) slip_seen++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end at a falling edge
    task automatic words(input logic [1:0] h, input int n);
        for (int i = 0; i < n; i++) begin
            din_valid = 1'b1;
            din_hdr   = h;
            @(negedge clk);
        end
        din_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        sclr = 1'b1;
        @(negedge clk);
        sclr = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".slip"}, 32'(slip), 32'd0);
        chk({tag, ".slipping"}, 32'(slipping), 32'd0);
        chk({tag, ".locked"}, 32'(word_locked), 32'd0);
        chk({tag, ".slip_count"}, 32'(slip_count), 32'd0);
        chk({tag, ".loss_count"}, 32'(lock_loss_count), 32'd0);
    endtask

    initial begin
        idle(2);
        sclr = 1'b0;
        chk_all_zero("reset");

        // 1: clean stream locks one cycle after the 64th good header
        slip_base = slip_seen;
        words(2'b01, 63);
        chk("t1.not_yet", 32'(word_locked), 32'd0);
        words(2'b01, 1);
        chk("t1.locked", 32'(word_locked), 32'd1);
        idle(1);
        chk("t1.no_slip", 32'(slip_seen - slip_base), 32'd0);
        chk("t1.slip_count", 32'(slip_count), 32'd0);

        // 2: three bad headers while hunting -> three slips, then lock
        do_reset();
        slip_base = slip_seen;
        for (int k = 0; k < 3; k++) begin
            words(2'b11, 1);
            chk("t2.slip_pulse", 32'(slip), 32'd1);
            chk("t2.slipping", 32'(slipping), 32'd1);
            chk("t2.slip_count", 32'(slip_count), 32'(k + 1));
            if (k == 1) words(2'b11, 1);  // consumed by the slip cycle
            else idle(1);
            chk("t2.slip_end", 32'(slip), 32'd0);
            words(2'b00, 3);              // headers ignored while waiting
            chk("t2.still_wait", 32'(slipping), 32'd1);
            words(2'b00, 1);
            chk("t2.wait_done", 32'(slipping), 32'd0);
        end
        words(2'b01, 63);
        chk("t2.not_yet", 32'(word_locked), 32'd0);
        words(2'b01, 1);
        chk("t2.locked", 32'(word_locked), 32'd1);
        chk("t2.slips_seen", 32'(slip_seen - slip_base), 32'd3);

        // 3: 15 bad headers tolerated, 16th in the same window drops lock
        words(2'b11, 15);
        chk("t3.held", 32'(word_locked), 32'd1);
        words(2'b00, 1);
        chk("t3.lost", 32'(word_locked), 32'd0);
        chk("t3.loss_count", 32'(lock_loss_count), 32'd1);
        chk("t3.slip_pulse", 32'(slip), 32'd1);
        chk("t3.slip_count", 32'(slip_count), 32'd4);
        idle(1);
        words(2'b01, 4);
        words(2'b01, 64);
        chk("t3.relocked", 32'(word_locked), 32'd1);

        // 4: bad counts clear at the window boundary
        words(2'b01, 49);
        words(2'b11, 15);
        chk("t4.win1_held", 32'(word_locked), 32'd1);
        words(2'b11, 15);
        chk("t4.win2_held", 32'(word_locked), 32'd1);
        words(2'b11, 1);
        chk("t4.lost", 32'(word_locked), 32'd0);
        chk("t4.loss_count", 32'(lock_loss_count), 32'd2);
        idle(1);

        // 5: slip disabled -> never slip; lock loss goes straight to hunt
        do_reset();
        slip_enable = 1'b0;
        slip_base = slip_seen;
        words(2'b00, 200);
        idle(1);
        chk("t5.no_slip", 32'(slip_seen - slip_base), 32'd0);
        chk("t5.unlocked", 32'(word_locked), 32'd0);
        chk("t5.slip_count", 32'(slip_count), 32'd0);
        words(2'b10, 64);
        chk("t5.locked", 32'(word_locked), 32'd1);
        words(2'b11, 16);
        chk("t5.lost", 32'(word_locked), 32'd0);
        chk("t5.no_slip_on_loss", 32'(slip), 32'd0);
        chk("t5.not_slipping", 32'(slipping), 32'd0);
        chk("t5.loss_count", 32'(lock_loss_count), 32'd1);
        words(2'b10, 64);
        chk("t5.relocked", 32'(word_locked), 32'd1);

        // 6: sclr during WAIT, during a would-be slip, and during LOCKED
        slip_enable = 1'b1;
        do_reset();
        words(2'b11, 1);
        idle(1);
        words(2'b01, 1);
        chk("t6.in_wait", 32'(slipping), 32'd1);
        do_reset();
        chk_all_zero("t6.wait_rst");
        sclr = 1'b1;
        words(2'b00, 1);
        sclr = 1'b0;
        chk("t6.rst_blocks_slip", 32'(slip), 32'd0);
        words(2'b01, 32);
        idle(5);  // gaps do not disturb the good-header run
        words(2'b01, 31);
        chk("t6.not_yet", 32'(word_locked), 32'd0);
        words(2'b01, 1);
        chk("t6.locked", 32'(word_locked), 32'd1);
        do_reset();
        chk_all_zero("t6.lock_rst");
        words(2'b01, 63);
        chk("t6.relock_not_yet", 32'(word_locked), 32'd0);
        words(2'b01, 1);
        chk("t6.relocked", 32'(word_locked), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
